hazard_scoreboard: RTL and testbench

//  Parametrised scoreboard hazard unit for the pipelined MIPS core. Sits between decode and the datapath.

---
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register ready countdowns, RAW stall, bypass select, branch flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int LAT_W      = 3,
    parameter int MAX_LAT    = 4,
    parameter int BR_PENALTY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_uses_rt,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_reg_write,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush,
    output logic             issue_ok,
    output logic             fwd_a,
    output logic             fwd_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_cycles
`endif
);

    localparam int unsigned NREG = 2 ** AW;
    localparam int FW = $clog2(BR_PENALTY + 1);

    logic [NREG-1:0]  busy;
    logic [LAT_W-1:0] cnt [NREG];
    logic [FW-1:0]    fcnt;
    logic             rdy_a;
    logic             rdy_b;
    logic             alloc;
    logic [LAT_W-1:0] lat_clamp;

    always_comb begin
        flush     = (fcnt != '0);
        rdy_a     = (id_rs == '0) || !busy[id_rs] || (cnt[id_rs] == '0);
        rdy_b     = (id_rt == '0) || !busy[id_rt] || (cnt[id_rt] == '0);
        fwd_a     = (id_rs != '0) && busy[id_rs] && (cnt[id_rs] == '0);
        fwd_b     = (id_rt != '0) && busy[id_rt] && (cnt[id_rt] == '0);
        stall     = id_valid & ~flush & (~rdy_a | (id_uses_rt & ~rdy_b));
        issue_ok  = rst_n & id_valid & ~stall & ~flush;
        alloc     = issue_ok & id_reg_write & (id_rd != '0);
        lat_clamp = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
    end

    // Allocation overrides both writeback clear and countdown for the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (alloc && (id_rd == AW'(r))) begin
                    busy[r] <= 1'b1;
                    cnt[r]  <= lat_clamp;
                end else begin
                    if (wb_valid && (wb_rd == AW'(r))) begin
                        busy[r] <= 1'b0;
                    end
                    if (busy[r] && (cnt[r] != '0)) begin
                        cnt[r] <= cnt[r] - LAT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (branch_taken) begin
            fcnt <= FW'(BR_PENALTY);
        end else if (flush) begin
            fcnt <= fcnt - FW'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush && (flush_cycles != '1)) begin
                flush_cycles <= flush_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: timestamp-based reference model checked every cycle,
// plus literal expectations at key points. Stats checks compile in with HAZARD_STATS_EN.
module tb_hazard_scoreboard;

    localparam int P    = 2;
    localparam int MAXL = 4;
    localparam int NR   = 32;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       id_valid     = 1'b1;
    logic [4:0] id_rs        = '0;
    logic [4:0] id_rt        = '0;
    logic       id_uses_rt   = 1'b0;
    logic [4:0] id_rd        = '0;
    logic       id_reg_write = 1'b0;
    logic [2:0] id_lat       = '0;
    logic       wb_valid     = 1'b0;
    logic [4:0] wb_rd        = '0;
    logic       branch_taken = 1'b0;
    logic       stall, flush, issue_ok, fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_cycles;
`endif

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.AW(5), .LAT_W(3), .MAX_LAT(MAXL), .BR_PENALTY(P)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_taken(branch_taken),
        .stall(stall), .flush(flush), .issue_ok(issue_ok), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Model: a pending register becomes forwardable at an absolute cycle number;
    // flush is active for the P cycles following the most recent branch.
    bit pend  [NR];
    int avail [NR];
    int cyc     = 0;
    int last_br = -1000;
    int m_sc    = 0;
    int m_fc    = 0;

    function automatic bit m_ready(input logic [4:0] r);
        return (r == 0) || !pend[r] || (avail[r] <= cyc);
    endfunction

    function automatic bit m_fwd(input logic [4:0] r);
        return (r != 0) && pend[r] && (avail[r] <= cyc);
    endfunction

    function automatic bit m_flush();
        return rst_n && ((cyc - last_br) >= 1) && ((cyc - last_br) <= P);
    endfunction

    function automatic bit m_stall();
        return rst_n && id_valid && !m_flush() &&
               (!m_ready(id_rs) || (id_uses_rt && !m_ready(id_rt)));
    endfunction

    function automatic bit m_issue();
        return rst_n && id_valid && !m_stall() && !m_flush();
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state update on each active edge (or on reset assertion).
    initial begin
        bit st, fl, iss;
        int l;
        for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; avail[i] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NR; i++) pend[i] = 1'b0;
                last_br = -1000;
                m_sc = 0;
                m_fc = 0;
            end else begin
                st  = m_stall();
                fl  = m_flush();
                iss = m_issue();
                if (wb_valid && (wb_rd != 0)) pend[wb_rd] = 1'b0;
                if (iss && id_reg_write && (id_rd != 0)) begin
                    l = (int'(id_lat) > MAXL) ? MAXL : int'(id_lat);
                    pend[id_rd]  = 1'b1;
                    avail[id_rd] = cyc + 1 + l;
                end
                if (branch_taken) last_br = cyc;
                if (st && (m_sc < 65535)) m_sc++;
                if (fl && (m_fc < 65535)) m_fc++;
                cyc++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        bit e_is;
        forever begin
            @(negedge clk);
            e_is = m_issue();
            chk1("flush", flush, m_flush());
            chk1("stall", stall, m_stall());
            chk1("issue_ok", issue_ok, e_is);
            if (!rst_n) begin
                chk1("rst_fwd_a", fwd_a, 1'b0);
                chk1("rst_fwd_b", fwd_b, 1'b0);
            end else if (e_is) begin
                chk1("fwd_a", fwd_a, m_fwd(id_rs));
                chk1("fwd_b", fwd_b, m_fwd(id_rt));
            end
`ifdef HAZARD_STATS_EN
            chk16("stall_cycles", stall_cycles, 16'(m_sc));
            chk16("flush_cycles", flush_cycles, 16'(m_fc));
`endif
        end
    end

    task automatic op(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] rd, input logic rw, input logic [2:0] lat,
                      input logic wbv, input logic [4:0] wbrd, input logic br);
        @(posedge clk); #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_reg_write = rw; id_lat = lat;
        wb_valid = wbv; wb_rd = wbrd; branch_taken = br;
        @(negedge clk);
    endtask

    task automatic idle();
        op(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        // Reset with a valid instruction presented: nothing may issue.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_flush", flush, 1'b0);
        chk1("reset_issue", issue_ok, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; id_valid = 1'b0;

        // ALU back-to-back with zero latency, then writeback.
        op(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        chk1("alu_issue", issue_ok, 1'b1);
        op(1, 3, 3, 1, 0, 0, 0, 0, 0, 0);
        chk1("alu_stall", stall, 1'b0);
        chk1("alu_fwd_a", fwd_a, 1'b1);
        chk1("alu_fwd_b", fwd_b, 1'b1);
        op(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        op(1, 3, 3, 1, 0, 0, 0, 0, 0, 0);
        chk1("wb_fwd_a", fwd_a, 1'b0);
        chk1("wb_fwd_b", fwd_b, 1'b0);

        // Load-use with latency 2: two stall cycles, then forward.
        op(1, 0, 0, 0, 8, 1, 2, 0, 0, 0);
        op(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("lu_stall1", stall, 1'b1);
        op(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("lu_stall2", stall, 1'b1);
        op(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("lu_release", issue_ok, 1'b1);
        chk1("lu_fwd_a", fwd_a, 1'b1);

        // Latency 7 clamps to 4.
        op(1, 0, 0, 0, 9, 1, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            op(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
            chk1("clamp_stall", stall, 1'b1);
        end
        op(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("clamp_release", stall, 1'b0);

        // Busy rt only matters when the instruction reads it.
        op(1, 0, 0, 0, 10, 1, 3, 0, 0, 0);
        op(1, 0, 10, 0, 0, 0, 0, 0, 0, 0);
        chk1("no_rt_stall", stall, 1'b0);
        op(1, 0, 10, 1, 0, 0, 0, 0, 0, 0);
        chk1("rt_stall", stall, 1'b1);
        repeat (3) idle();

        // Same-cycle issue and writeback to r7: issue wins.
        op(1, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        op(1, 0, 0, 0, 7, 1, 3, 1, 7, 0);
        op(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("same_cyc_stall", stall, 1'b1);
        op(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        op(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("wbclr_stall", stall, 1'b0);
        chk1("wbclr_fwd_a", fwd_a, 1'b0);
        op(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk1("r0_stall", stall, 1'b0);
        chk1("r0_fwd_a", fwd_a, 1'b0);

        // Branch: two flush cycles, no allocation while flushing.
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        op(1, 0, 0, 0, 14, 1, 4, 0, 0, 0);
        chk1("br_flush1", flush, 1'b1);
        chk1("br_issue1", issue_ok, 1'b0);
        op(1, 0, 0, 0, 14, 1, 4, 0, 0, 0);
        chk1("br_flush2", flush, 1'b1);
        op(1, 14, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("br_end_flush", flush, 1'b0);
        chk1("br_no_alloc", stall, 1'b0);

        // Re-pulse during the first flush cycle: three flush cycles in all.
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk1("rebr_flush1", flush, 1'b1);
        idle();
        chk1("rebr_flush2", flush, 1'b1);
        idle();
        chk1("rebr_flush3", flush, 1'b1);
        idle();
        chk1("rebr_end", flush, 1'b0);

        // Flush overrides a pending stall.
        op(1, 0, 0, 0, 13, 1, 4, 0, 0, 0);
        op(1, 13, 0, 0, 0, 0, 0, 0, 0, 1);
        chk1("brst_stall", stall, 1'b1);
        op(1, 13, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("brst_flush", flush, 1'b1);
        chk1("brst_nostall", stall, 1'b0);
        repeat (4) op(1, 13, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-run discards r5 and an active flush.
        op(1, 0, 0, 0, 5, 1, 3, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; id_valid = 1'b1; id_rs = 5'd5; id_rd = '0; id_reg_write = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        chk1("midrst_stall", stall, 1'b0);
        chk1("midrst_flush", flush, 1'b0);
        chk1("midrst_issue", issue_ok, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("postrst_stall", stall, 1'b0);
        chk1("postrst_fwd_a", fwd_a, 1'b0);
        chk1("postrst_issue", issue_ok, 1'b1);

`ifdef HAZARD_STATS_EN
        @(posedge clk); #1;
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(1, 0, 0, 0, 20, 1, 3, 0, 0, 0);
        repeat (4) op(1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) idle();
        chk16("stats_stall3", stall_cycles, 16'd3);
        chk16("stats_flush2", flush_cycles, 16'd2);
        // Repeating issue to r21 with latency 4 gives four stalls per five cycles.
        repeat (87500) op(1, 21, 0, 0, 21, 1, 4, 0, 0, 0);
        chk16("stats_sat", stall_cycles, 16'hFFFF);
`endif

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
